// File: rtl/bounce_monitor_pkg.sv
// Shared definitions for the bouncing-LED bar observer and other LED-bar consumers.
package bounce_monitor_pkg;

  localparam int LED_COUNT = 10;
  localparam int INDEX_W   = 4;

  // Ball tracking states: IDLE until the first valid sample, STILL until the first move.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STILL   = 2'd1,
    RISING  = 2'd2,
    FALLING = 2'd3
  } state_t;

endpackage

// File: rtl/onehot10_decode.sv
// Combinational decoder for the 10-LED bar: flags whether exactly one LED is lit
// and reports its bit position.
module onehot10_decode
  import bounce_monitor_pkg::*;
(
  input  logic [LED_COUNT-1:0] led,
  output logic                 valid,
  output logic [INDEX_W-1:0]   index
);

  // Count lit LEDs and remember the position of the (last) lit one.
  always_comb begin
    logic [INDEX_W-1:0] ones;
    ones  = '0;
    index = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (led[i]) begin
        ones  = ones + 1'b1;
        index = INDEX_W'(i);
      end
    end
    valid = (ones == INDEX_W'(1));
  end

endmodule

// File: rtl/bounce_monitor.sv
// Receive-side observer for the bouncing-LED bar: recovers index, direction,
// apex, floor-bounce count and per-LED dwell time from the sampled LED bar.
// Optional feature macro: BOUNCE_MONITOR_HEX_EN adds HEX0/HEX1 displays of
// Bounce_count (needs COUNT_W >= 8).
module bounce_monitor
  import bounce_monitor_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int COUNT_W = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset_n,
  input  logic                 Sample,
  input  logic [LED_COUNT-1:0] LEDR_in,
  output logic [INDEX_W-1:0]   Index,
  output logic                 Direction,
  output logic                 Tracking,
  output logic [INDEX_W-1:0]   Peak_index,
  output logic [COUNT_W-1:0]   Bounce_count,
  output logic [DWELL_W-1:0]   Dwell,
  output logic                 Event_valid,
`ifdef BOUNCE_MONITOR_HEX_EN
  output logic [7:0]           HEX0,
  output logic [7:0]           HEX1,
`endif
  output logic                 Error
);

  state_t               state_reg, state_next;
  logic [INDEX_W-1:0]   index_reg, index_next;
  logic [INDEX_W-1:0]   peak_reg, peak_next;
  logic [COUNT_W-1:0]   bounce_reg, bounce_next;
  logic [DWELL_W-1:0]   dwell_cnt_reg, dwell_cnt_next;
  logic [DWELL_W-1:0]   dwell_reg, dwell_next;
  logic                 event_reg, event_next;
  logic                 error_reg, error_next;

  logic                 dec_valid;
  logic [INDEX_W-1:0]   dec_index;
  logic [DWELL_W-1:0]   dwell_cnt_inc;

  onehot10_decode u_decode (
    .led   (LEDR_in),
    .valid (dec_valid),
    .index (dec_index)
  );

  // Dwell counter advance, sticking at all-ones so long holds read as "very long".
  assign dwell_cnt_inc = (dwell_cnt_reg == '1) ? dwell_cnt_reg : dwell_cnt_reg + 1'b1;

  // Next-state and next-output logic; nothing moves unless Sample strobes.
  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    peak_next      = peak_reg;
    bounce_next    = bounce_reg;
    dwell_cnt_next = dwell_cnt_reg;
    dwell_next     = dwell_reg;
    event_next     = 1'b0;
    error_next     = error_reg;
    if (Sample) begin
      if (!dec_valid) begin
        // Corrupt bar: flag it, keep tracking state, but time still passes.
        error_next     = 1'b1;
        dwell_cnt_next = dwell_cnt_inc;
      end else if (state_reg == IDLE) begin
        state_next     = STILL;
        index_next     = dec_index;
        dwell_cnt_next = DWELL_W'(1);
      end else if (dec_index == index_reg) begin
        dwell_cnt_next = dwell_cnt_inc;
      end else begin
        if (dec_index > index_reg) begin
          state_next = RISING;
          // Leaving the floor after a descent is a bounce; a mid-bar kick is not.
          if (state_reg == FALLING && index_reg == '0 && bounce_reg != '1)
            bounce_next = bounce_reg + 1'b1;
        end else begin
          state_next = FALLING;
          if (state_reg == RISING)
            peak_next = index_reg;
        end
        dwell_next     = dwell_cnt_reg;
        dwell_cnt_next = DWELL_W'(1);
        index_next     = dec_index;
        event_next     = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      peak_reg      <= '0;
      bounce_reg    <= '0;
      dwell_cnt_reg <= '0;
      dwell_reg     <= '0;
      event_reg     <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      peak_reg      <= peak_next;
      bounce_reg    <= bounce_next;
      dwell_cnt_reg <= dwell_cnt_next;
      dwell_reg     <= dwell_next;
      event_reg     <= event_next;
      error_reg     <= error_next;
    end
  end

  assign Index        = index_reg;
  assign Direction    = (state_reg == RISING);
  assign Tracking     = (state_reg != IDLE);
  assign Peak_index   = peak_reg;
  assign Bounce_count = bounce_reg;
  assign Dwell        = dwell_reg;
  assign Event_valid  = event_reg;
  assign Error        = error_reg;

`ifdef BOUNCE_MONITOR_HEX_EN
  HEXDisplay u_hex0 (
    .hex_digit (Bounce_count[3:0]),
    .segments  (HEX0)
  );

  HEXDisplay u_hex1 (
    .hex_digit (Bounce_count[7:4]),
    .segments  (HEX1)
  );
`endif

endmodule

// File: tb/tb_bounce_monitor.sv
// Scoreboard bench for bounce_monitor: stimulus pushes expected outputs from a
// ball-behaviour model; a monitor pops and compares one cycle after each edge.
module tb_bounce_monitor;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Sample = 1'b0;
  logic [9:0] LEDR_in = '0;
  logic [3:0] Index;
  logic       Direction;
  logic       Tracking;
  logic [3:0] Peak_index;
  logic [7:0] Bounce_count;
  logic [15:0] Dwell;
  logic       Event_valid;
  logic       Error;

  always #5 clk = ~clk;

  bounce_monitor dut (
    .CLOCK_50     (clk),
    .Reset_n      (Reset_n),
    .Sample       (Sample),
    .LEDR_in      (LEDR_in),
    .Index        (Index),
    .Direction    (Direction),
    .Tracking     (Tracking),
    .Peak_index   (Peak_index),
    .Bounce_count (Bounce_count),
    .Dwell        (Dwell),
    .Event_valid  (Event_valid),
    .Error        (Error)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic        dir;
    logic        trk;
    logic [3:0]  peak;
    logic [7:0]  bc;
    logic [15:0] dwell;
    logic        ev;
    logic        err;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  // Reference model of the ball as seen on the bar.
  bit m_trk, m_err, m_ev;
  int m_idx, m_peak, m_bc, m_cnt, m_dwell;
  int m_move;  // +1 last move up, -1 last move down, 0 none yet

  function automatic void model_update(input logic rst_n, input logic smp, input logic [9:0] led);
    int pos;
    if (!rst_n) begin
      m_trk = 0; m_err = 0; m_ev = 0;
      m_idx = 0; m_peak = 0; m_bc = 0; m_cnt = 0; m_dwell = 0; m_move = 0;
      return;
    end
    m_ev = 0;
    if (!smp) return;
    if ($countones(led) != 1) begin
      m_err = 1;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      return;
    end
    pos = $clog2(led);
    if (!m_trk) begin
      m_trk = 1; m_idx = pos; m_cnt = 1; m_move = 0;
    end else if (pos == m_idx) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      if (pos > m_idx) begin
        if (m_move < 0 && m_idx == 0) m_bc = (m_bc < 255) ? m_bc + 1 : 255;
        m_move = 1;
      end else begin
        if (m_move > 0) m_peak = m_idx;
        m_move = -1;
      end
      m_dwell = m_cnt; m_cnt = 1; m_idx = pos; m_ev = 1;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.idx   = 4'(m_idx);
    o.dir   = (m_move > 0);
    o.trk   = m_trk;
    o.peak  = 4'(m_peak);
    o.bc    = 8'(m_bc);
    o.dwell = 16'(m_dwell);
    o.ev    = m_ev;
    o.err   = m_err;
    return o;
  endfunction

  // One clock of stimulus; the expected outcome of that edge is queued.
  task automatic step(input logic rst_n, input logic smp, input logic [9:0] led);
    @(negedge clk);
    Reset_n = rst_n; Sample = smp; LEDR_in = led;
    model_update(rst_n, smp, led);
    exp_q.push_back(model_obs());
  endtask

  task automatic val(input int i);
    logic [9:0] oh;
    oh = 10'b1 << i;
    step(1'b1, 1'b1, oh);
  endtask

  // Monitor: compares registered outputs just after each active edge.
  obs_t mon_exp, mon_act;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = '{Index, Direction, Tracking, Peak_index, Bounce_count, Dwell, Event_valid, Error};
        tests++;
        if (mon_act !== mon_exp) begin
          fails++;
          $display("FAIL outputs cycle %0d: got idx=%0d dir=%0b trk=%0b peak=%0d bc=%0d dwell=%0d ev=%0b err=%0b, want idx=%0d dir=%0b trk=%0b peak=%0d bc=%0d dwell=%0d ev=%0b err=%0b",
                   cycle, mon_act.idx, mon_act.dir, mon_act.trk, mon_act.peak, mon_act.bc, mon_act.dwell, mon_act.ev, mon_act.err,
                   mon_exp.idx, mon_exp.dir, mon_exp.trk, mon_exp.peak, mon_exp.bc, mon_exp.dwell, mon_exp.ev, mon_exp.err);
        end
      end
    end
  end

  initial begin
    int cur, wd, r;
    logic [9:0] rnd;
    // Reset
    step(1'b0, 1'b0, 10'h000);
    step(1'b0, 1'b1, 10'h3FF);
    // First rise: 0 x3, 1, 2
    val(0); val(0); val(0); val(1); val(2);
    // Rise to 5, fall, floor bounce
    for (int i = 3; i <= 5; i++) val(i);
    val(4); val(3); val(2); val(1); val(0); val(1);
    // Rise to 4, fall to 3, kick upward
    val(2); val(3); val(4); val(3); val(4);
    // Invalid samples mid-track, idle cycles, then normal
    step(1'b1, 1'b1, 10'h000);
    step(1'b1, 1'b1, 10'h003);
    step(1'b1, 1'b0, 10'h001);
    step(1'b1, 1'b1, 10'h3FF);
    val(3); val(3); val(2);
    // Floor dwell saturation
    val(1); val(0);
    for (int i = 0; i < 70000; i++) val(0);
    val(1);
    // Bounce counter saturation
    val(0);
    for (int i = 0; i < 300; i++) begin val(1); val(0); end
    val(1);
    // Reset while rising, then restart
    val(2);
    step(1'b0, 1'b1, 10'h008);
    val(4); val(4); val(5);
    // Randomized walk
    cur = 5; wd = 1;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        rnd = 10'($urandom);
        step(1'b1, 1'b1, rnd);
      end else if (r < 14) begin
        rnd = 10'($urandom);
        step(1'b1, 1'b0, rnd);
      end else if (r < 16) begin
        rnd = 10'($urandom);
        step(1'b0, 1'($urandom_range(0, 1)), rnd);
      end else if (r < 22) begin
        cur = $urandom_range(0, 9);
        val(cur);
      end else if (r < 30) begin
        val(cur);
      end else begin
        if (r < 33) wd = -wd;
        if (cur == 9) wd = -1;
        if (cur == 0) wd = 1;
        cur = cur + wd;
        val(cur);
      end
    end
    // Drain the scoreboard, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bounce_monitor.md
# bounce_monitor

Receive-side observer for the bouncing-LED bar. Samples the 10-bit one-hot LED bar on each physics time-step strobe and recovers the ball state from it: current LED index, direction of travel, apex index, floor-bounce count and per-LED dwell time. It sits beside the physics/LED driver on the same 50 MHz clock and feeds the HEX displays or a logic-analyser tap.

## Interface
- DWELL_W, 16, width of the dwell counter and the Dwell output
- COUNT_W, 8, width of Bounce_count
- CLOCK_50  in  1  system clock; all logic on its rising edge
- Reset_n  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- Sample  in  1  one-cycle time-step strobe from the 20.48 us timer
- LEDR_in  in  10  LED bar as driven by the physics block; same clock domain, no synchroniser
- Index  out  4  last valid decoded LED index, 0..9
- Direction  out  1  1 = rising (index increasing), 0 = falling or still
- Tracking  out  1  high once any valid sample has been taken
- Peak_index  out  4  index at the most recent RISING->FALLING reversal
- Bounce_count  out  COUNT_W  floor bounces since reset, saturating
- Dwell  out  DWELL_W  samples spent on the previous index, captured at each index change
- Event_valid  out  1  one-cycle pulse on each index change
- Error  out  1  sticky; set by any non-one-hot sample
- HEX0, HEX1  out  8 each  Bounce_count nibbles, only with BOUNCE_MONITOR_HEX_EN

## Operation
- A sample is valid iff exactly one bit of LEDR_in is set. Index = bit position.
- Invalid sample: Error <= 1 (sticky until reset); state, Index and Event_valid unchanged; dwell counter still increments.
- FSM states: IDLE, STILL, RISING, FALLING.
  - IDLE: first valid sample -> STILL; Index <= i; dwell counter <= 1; Tracking <= 1; no Event_valid.
  - Any tracking state, valid sample, i == Index: dwell counter += 1, saturating at 2^DWELL_W-1. No state change.
  - Valid sample, i > Index: -> RISING. If the previous state was FALLING and old Index == 0, Bounce_count += 1 (saturates at 2^COUNT_W-1).
  - Valid sample, i < Index: -> FALLING. If the previous state was RISING, Peak_index <= old Index.
  - On any index change: Dwell <= dwell counter; dwell counter <= 1; Index <= i; Event_valid pulses.
- Jumps of more than one LED are accepted as normal index changes.
- A FALLING->RISING reversal at index > 0 (KEY_1 kick) changes direction but does not count as a bounce.
- Direction = 1 in RISING, 0 otherwise.

## Timing
- All updates occur on the CLOCK_50 edge that samples Sample = 1. Outputs are registered and visible the following cycle. Latency is 1 clock from the strobe.
- Sample high on consecutive cycles: each cycle is a separate sample.
- Sample low: no state change, and the dwell counter holds.
- Reset_n low takes priority over Sample. Every output and the FSM return to reset values on that edge, including mid-tracking.
- Reset values: Index 0, Direction 0, Tracking 0, Peak_index 0, Bounce_count 0, Dwell 0, Event_valid 0, Error 0, state IDLE, dwell counter 0.

## Configuration
- BOUNCE_MONITOR_HEX_EN defined:
  - two HEXDisplay instances drive HEX0 (Bounce_count[3:0]) and HEX1 (Bounce_count[7:4]);
  - requires COUNT_W >= 8.
- BOUNCE_MONITOR_HEX_EN undefined: HEX0 and HEX1 ports and instances are absent. All other behaviour is identical.

## Structure
- Package bounce_monitor_pkg:
  - state enum (IDLE, STILL, RISING, FALLING);
  - LED_COUNT = 10;
  - INDEX_W = 4.
- Sub-module onehot10_decode: combinational, LEDR_in -> {valid, index[3:0]}; reused by other LED-bar consumers.
- HEXDisplay is reused unchanged.

## Test plan
- Reset then sequence 0x001 x3, 0x002, 0x004 (one strobe each) -> Tracking = 1, state RISING, Index 2, Direction 1; Event_valid pulses twice; Dwell = 3 after the first change, then 1.
- Rise 0..5, then 0x010 -> Peak_index = 5, Direction 0; then fall to 0x001, then 0x002 -> Bounce_count = 1.
- Fall to index 3, then 0x010 (kick) -> Direction 1, Bounce_count unchanged, Peak_index unchanged.
- Samples 0x000 and 0x003 mid-track -> Error = 1 and stays 1; Index unchanged; no Event_valid; next valid sample is processed normally.
- Hold 0x001 for 70000 strobes, then 0x002 -> Dwell = 65535 (saturated). Force 300 floor bounces -> Bounce_count = 255.
- Assert Reset_n low on a cycle with Sample = 1 while RISING -> all outputs at reset values next cycle. The next valid sample produces STILL with no Event_valid.
